// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared FSM state type and counter sizing helpers for reset_sequencer.
// No ports; imported by reset_sequencer and reset_seq_channel.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_ASSERT,
        S_DEBOUNCE,
        S_RELEASE,
        S_RUN,
        S_SW_PULSE
    } state_e;

    // Release count at which channel k comes out of reset.
    function automatic int rel_thresh(input int base, input int stagger, input int k);
        return base + k * stagger;
    endfunction

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_seq_channel.sv
// reset_seq_channel: one reset output -- release flag, hold gating and output register.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   active      : sequencer is (or is about to be) in RELEASE or RUN
//   cnt_d       : release counter value being loaded on this edge
//   hold        : keep this channel in reset
//   out         : registered (flag & ~hold), before combinational resetn gating
module reset_seq_channel import reset_seq_pkg::*; #(
    parameter int CW     = 8,
    parameter int THRESH = 0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          active,
    input  logic [CW-1:0] cnt_d,
    input  logic          hold,
    output logic          out
);

    logic flag_q, flag_d, out_q, out_d;

    // The flag is sampled from the counter's next value so the output register
    // rises on the very edge the count reaches THRESH.
    always_comb begin
        flag_d = active & (flag_q | (int'(cnt_d) >= THRESH));
        out_d  = flag_d & ~hold;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            flag_q <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: debounces resetn, then releases CHANNELS reset outputs in a staggered order.
// Ports:
//   clk, resetn  : clock and synchronous active-low reset (also gates outputs combinationally)
//   sw_reset_req : single-cycle request to re-run the release sequence
//   ch_hold      : per-channel hold-in-reset requests
//   resetn_out   : per-channel active-low reset outputs
//   all_released : every channel released and no hold set
//   busy         : sequencer not in RUN
module reset_sequencer import reset_seq_pkg::*; #(
    parameter int CHANNELS     = 4,
    parameter int BASE_STRETCH = 20,
    parameter int STAGGER      = 16,
    parameter int DEBOUNCE     = 4,
    parameter int SW_PULSE_LEN = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                sw_reset_req,
    input  logic [CHANNELS-1:0] ch_hold,
    output logic [CHANNELS-1:0] resetn_out,
    output logic                all_released,
    output logic                busy
);

    localparam int LAST_T = rel_thresh(BASE_STRETCH, STAGGER, CHANNELS - 1);
    localparam int CW     = cnt_width(LAST_T);
    localparam int AW     = cnt_width(DEBOUNCE > SW_PULSE_LEN ? DEBOUNCE : SW_PULSE_LEN);

    if (CHANNELS < 1 || CHANNELS > 16 || BASE_STRETCH < 0 || STAGGER < 0 ||
        DEBOUNCE < 0 || SW_PULSE_LEN < 1) begin : g_bad_params
        $error("reset_sequencer: illegal parameter value");
    end

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       aux_q, aux_d;
    logic                active;
    logic [CHANNELS-1:0] ch_out;

    // aux counts debounce samples in DEBOUNCE and pulse cycles in SW_PULSE.
    always_comb begin
        state_d = state_q;
        aux_d   = '0;
        if (!resetn) begin
            state_d = S_ASSERT;
        end else begin
            case (state_q)
                S_ASSERT:   state_d = (DEBOUNCE == 0) ? S_RELEASE : S_DEBOUNCE;
                S_DEBOUNCE: begin
                    state_d = (int'(aux_q) == DEBOUNCE - 1) ? S_RELEASE : S_DEBOUNCE;
                    aux_d   = aux_q + AW'(1);
                end
                S_RELEASE:  state_d = sw_reset_req ? S_SW_PULSE :
                                      (int'(cnt_q) + 1 >= LAST_T) ? S_RUN : S_RELEASE;
                S_RUN:      state_d = sw_reset_req ? S_SW_PULSE : S_RUN;
                S_SW_PULSE: begin
                    state_d = (int'(aux_q) == SW_PULSE_LEN) ? S_RELEASE : S_SW_PULSE;
                    aux_d   = (int'(aux_q) == SW_PULSE_LEN) ? '0 : aux_q + AW'(1);
                end
                default:    state_d = S_ASSERT;
            endcase
        end
        active = (state_d == S_RELEASE) || (state_d == S_RUN);
        // Counter starts at 0 on entry to RELEASE, counts while there, freezes in RUN.
        cnt_d  = (state_q == S_RELEASE && active) ? cnt_q + CW'(1) :
                 (state_q == S_RUN && state_d == S_RUN) ? cnt_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_ASSERT;
            cnt_q   <= '0;
            aux_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aux_q   <= aux_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        reset_seq_channel #(
            .CW     (CW),
            .THRESH (rel_thresh(BASE_STRETCH, STAGGER, k))
        ) u_ch (
            .clk    (clk),
            .resetn (resetn),
            .active (active),
            .cnt_d  (cnt_d),
            .hold   (ch_hold[k]),
            .out    (ch_out[k])
        );
    end

    // resetn gates outputs directly so assertion takes effect without waiting for an edge.
    assign resetn_out   = ch_out & {CHANNELS{resetn}};
    assign all_released = (&resetn_out) & ~(|ch_hold);
    assign busy         = (state_q != S_RUN) | ~resetn;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table vectors, directed corner cases and random stimulus against a timeline model.
module tb_reset_sequencer;

    localparam int DEB   = 4;
    localparam int SWLEN = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0, sw_reset_req = 1'b0;
    logic [3:0] ch_hold = '0;
    logic [3:0] resetn_out;
    logic       all_released, busy;
    logic       resetn1 = 1'b0, sw1 = 1'b0, hold1 = 1'b0;
    logic       out1, all1, busy1;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk(clk), .resetn(resetn), .sw_reset_req(sw_reset_req), .ch_hold(ch_hold),
        .resetn_out(resetn_out), .all_released(all_released), .busy(busy)
    );

    reset_sequencer #(.CHANNELS(1), .DEBOUNCE(0)) dut1 (
        .clk(clk), .resetn(resetn1), .sw_reset_req(sw1), .ch_hold(hold1),
        .resetn_out(out1), .all_released(all1), .busy(busy1)
    );

    int checks = 0, errors = 0;

    // Timeline model: origin is the edge at which release timing starts (t=0);
    // channel k is released from edge origin + T_k while the sequence stays valid.
    int         edge_n = 0, origin = 0;
    bit         seq_v = 0, run_m = 0;
    logic [3:0] out_m = '0;

    function automatic int t_of(input int k);
        return 20 + 16 * k;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_chk(input string tag);
        logic [3:0] e;
        e = out_m & {4{resetn}};
        chk({tag, "_out"}, 32'(resetn_out), 32'(e));
        chk({tag, "_all"}, 32'(all_released), 32'((&e) & ~(|ch_hold)));
        chk({tag, "_busy"}, 32'(busy), 32'(!resetn || !run_m));
    endtask

    task automatic step(input logic rn, input logic sw, input logic [3:0] hold);
        resetn = rn;
        sw_reset_req = sw;
        ch_hold = hold;
        #1 model_chk("pre");
        @(posedge clk);
        if (!rn) seq_v = 0;
        else if (!seq_v) begin
            seq_v = 1;
            origin = edge_n + DEB;
        end else if (sw && edge_n > origin) origin = edge_n + SWLEN + 1;
        for (int k = 0; k < 4; k++) out_m[k] = seq_v && edge_n >= origin + t_of(k) && !hold[k];
        run_m = seq_v && edge_n >= origin + t_of(3);
        edge_n++;
        @(negedge clk);
        model_chk("post");
    endtask

    typedef struct {
        bit rf; int at; logic rn; logic sw; logic [3:0] hold;
        logic [3:0] e_out; logic e_all; logic e_busy;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rf, input int at, input logic rn, input logic sw, input logic [3:0] hold,
                       input logic [3:0] e_out, input logic e_all, input logic e_busy);
        vec_t x;
        x.rf = rf; x.at = at; x.rn = rn; x.sw = sw; x.hold = hold;
        x.e_out = e_out; x.e_all = e_all; x.e_busy = e_busy;
        tbl.push_back(x);
    endtask

    initial begin
        int rel, rst_left, rise;
        logic rn_r, sw_r;
        logic [3:0] hold_r;
        // Default schedule: releases at 24, 40, 56, 72
        add(1, 23, 1, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 24, 1, 0, 4'b0000, 4'b0001, 0, 1);
        add(0, 39, 1, 0, 4'b0000, 4'b0001, 0, 1);
        add(0, 40, 1, 0, 4'b0000, 4'b0011, 0, 1);
        add(0, 55, 1, 0, 4'b0000, 4'b0011, 0, 1);
        add(0, 56, 1, 0, 4'b0000, 4'b0111, 0, 1);
        add(0, 71, 1, 0, 4'b0000, 4'b0111, 0, 1);
        add(0, 72, 1, 0, 4'b0000, 4'b1111, 1, 0);
        // ch_hold[1] until edge 100
        add(1, 24, 1, 0, 4'b0010, 4'b0001, 0, 1);
        add(0, 40, 1, 0, 4'b0010, 4'b0001, 0, 1);
        add(0, 56, 1, 0, 4'b0010, 4'b0101, 0, 1);
        add(0, 72, 1, 0, 4'b0010, 4'b1101, 0, 0);
        add(0, 100, 1, 0, 4'b0010, 4'b1101, 0, 0);
        add(0, 101, 1, 0, 4'b0000, 4'b1111, 1, 0);
        // software reset in RUN at edge 200
        add(0, 199, 1, 0, 4'b0000, 4'b1111, 1, 0);
        add(0, 200, 1, 1, 4'b0000, 4'b0000, 0, 1);
        add(0, 208, 1, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 228, 1, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 229, 1, 0, 4'b0000, 4'b0001, 0, 1);
        add(0, 245, 1, 0, 4'b0000, 4'b0011, 0, 1);
        add(0, 261, 1, 0, 4'b0000, 4'b0111, 0, 1);
        add(0, 277, 1, 0, 4'b0000, 4'b1111, 1, 0);
        // resetn drop at edge 50 mid-release, restart from edge 54
        add(1, 49, 1, 0, 4'b0000, 4'b0011, 0, 1);
        add(0, 50, 0, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 53, 0, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 77, 1, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 78, 1, 0, 4'b0000, 4'b0001, 0, 1);
        add(0, 126, 1, 0, 4'b0000, 4'b1111, 1, 0);
        // two-cycle glitch, then a clean rise at edge 31
        add(1, 1, 1, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 5, 0, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 30, 0, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 54, 1, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 55, 1, 0, 4'b0000, 4'b0001, 0, 1);
        // sw_reset_req during DEBOUNCE is ignored
        add(1, 0, 1, 0, 4'b0000, 4'b0000, 0, 1);
        add(0, 2, 1, 1, 4'b0000, 4'b0000, 0, 1);
        add(0, 24, 1, 0, 4'b0000, 4'b0001, 0, 1);
        rel = 0;
        foreach (tbl[i]) begin
            if (tbl[i].rf) begin
                repeat (3) step(1'b0, 1'b0, 4'b0);
                rel = 0;
            end
            while (rel <= tbl[i].at) begin
                step(tbl[i].rn, tbl[i].sw, tbl[i].hold);
                rel++;
            end
            chk($sformatf("vec%0d_out", i), 32'(resetn_out), 32'(tbl[i].e_out));
            chk($sformatf("vec%0d_all", i), 32'(all_released), 32'(tbl[i].e_all));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end
        // Zero-latency assertion from RUN
        repeat (50) step(1'b1, 1'b0, 4'b0);
        chk("gate_before_out", 32'(resetn_out), 32'hF);
        resetn = 1'b0;
        #1;
        chk("gate_comb_out", 32'(resetn_out), 32'h0);
        chk("gate_comb_busy", 32'(busy), 32'h1);
        chk("gate_comb_all", 32'(all_released), 32'h0);
        step(1'b0, 1'b0, 4'b0);
        // Random stimulus against the timeline model
        rst_left = 0;
        hold_r = '0;
        for (int i = 0; i < 3000; i++) begin
            if (rst_left > 0) begin
                rn_r = 1'b0;
                rst_left--;
            end else begin
                rn_r = 1'b1;
                if ($urandom_range(0, 149) == 0) rst_left = $urandom_range(1, 3);
            end
            sw_r = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) hold_r[$urandom_range(0, 3)] ^= 1'b1;
            step(rn_r, sw_r, hold_r);
        end
        // Single channel, no debounce: release 20 edges after the first high sample
        chk("ch1_reset_out", 32'(out1), 32'h0);
        chk("ch1_reset_busy", 32'(busy1), 32'h1);
        resetn1 = 1'b1;
        rise = -1;
        for (int i = 0; i < 100 && rise < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out1) rise = i;
        end
        chk("ch1_rise_edge", 32'(rise), 32'(20));
        chk("ch1_all_released", 32'(all1), 32'h1);
        chk("ch1_busy", 32'(busy1), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent reset outputs, legal 1..16.
REQ-002 Parameter BASE_STRETCH, default 20: clk cycles from debounce completion to release of channel 0.
REQ-003 Parameter STAGGER, default 16: extra clk cycles between releases of consecutive channels.
REQ-004 Parameter DEBOUNCE, default 4: consecutive high samples of resetn required before stretching starts; 0 disables.
REQ-005 Parameter SW_PULSE_LEN, default 8: clk cycles all outputs are held low on a software reset request; legal >= 1.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 resetn  input  1  synchronous, active-low reset.
REQ-008 sw_reset_req  input  1  single-cycle request to re-run the reset sequence.
REQ-009 ch_hold  input  CHANNELS  per-channel request to keep that channel in reset.
REQ-010 resetn_out  output  CHANNELS  per-channel active-low reset outputs.
REQ-011 all_released  output  1  high when every channel is released and no ch_hold bit is set.
REQ-012 busy  output  1  high in every state except RUN.

Function
REQ-013 The FSM SHALL have the states ASSERT, DEBOUNCE, RELEASE, RUN and SW_PULSE.
REQ-014 ASSERT: all outputs are low; the FSM moves to DEBOUNCE on the first edge that samples resetn high (to RELEASE directly if DEBOUNCE=0).
REQ-015 DEBOUNCE: the FSM counts consecutive high samples of resetn and enters RELEASE after DEBOUNCE samples.
REQ-016 RELEASE: a cycle counter starts at 0 on entry and increments each edge; channel k's release flag sets when the count reaches T_k = BASE_STRETCH + k*STAGGER.
REQ-017 With ch_hold low, resetn_out[k] SHALL rise exactly DEBOUNCE + T_k edges after the first edge that samples resetn high.
REQ-018 The FSM enters RUN on the edge on which the last release flag sets; the counter then stops.
REQ-019 resetn_out[k] = registered (release_flag[k] & ~ch_hold[k]), ANDed combinationally with resetn so reset assertion has zero-cycle latency.
REQ-020 ch_hold[k] SHALL delay only channel k; progression of other channels and of the FSM is unaffected.
REQ-021 Deassertion of ch_hold[k] after the flag is set releases channel k one edge later; assertion drops it one edge later.
REQ-022 sw_reset_req in RELEASE or RUN: next edge clears all release flags, enters SW_PULSE, and drives all outputs low for SW_PULSE_LEN cycles.
REQ-023 After SW_PULSE the FSM enters RELEASE directly; DEBOUNCE is skipped.
REQ-024 sw_reset_req is ignored in ASSERT, DEBOUNCE and SW_PULSE.
REQ-025 resetn low in any state SHALL win over every other event; it clears the counters and flags and enters ASSERT on the next edge.
REQ-026 Counter width = clog2(BASE_STRETCH + (CHANNELS-1)*STAGGER + 1); the counter SHALL never wrap.
REQ-027 Illegal parameter values SHALL cause an elaboration error.

Reset
REQ-028 While resetn is low: state = ASSERT, counters = 0, flags = 0, resetn_out = 0, all_released = 0, busy = 1.

Structure
REQ-029 Package reset_seq_pkg SHALL hold the FSM state typedef and the counter-width/threshold helper functions.
REQ-030 Sub-module reset_seq_channel SHALL hold the per-channel flag, hold gating and output register; it is instantiated CHANNELS times via generate.

Verification
REQ-031 Defaults, resetn rises at edge 0 -> resetn_out[0..3] rise at edges 24, 40, 56, 72; all_released and busy=0 from edge 72.
REQ-032 resetn glitches high for 2 cycles then low -> no output rises and the FSM returns to ASSERT.
REQ-033 ch_hold[1]=1 until edge 100 -> channels 0, 2 and 3 release on schedule; channel 1 rises at edge 101; all_released rises at edge 101.
REQ-034 sw_reset_req pulse in RUN at edge 200 -> all outputs low for edges 201-208, then channel k rises at edge 209 + 20 + 16k.
REQ-035 resetn low at edge 50 (mid RELEASE) -> resetn_out all 0 in the same cycle; full sequence restarts when resetn rises again.
REQ-036 CHANNELS=1, DEBOUNCE=0 -> resetn_out rises 20 edges after resetn rises.
